// File: rtl/fifo_write_scheduler.sv
// Round-robin arbiter sharing one FIFO write port between NUM_WRITERS writers, bounded bursts.
// Define FIFO_WRITE_SCHEDULER_STATS_EN to add per-writer word and stall counters.
module fifo_write_scheduler #(
    parameter int NUM_WRITERS = 4,
    parameter int DATA_W      = 8,
    parameter int MAX_BURST   = 4
) (
    input  logic                            i_clk,
    input  logic                            i_reset_n,
    input  logic [NUM_WRITERS-1:0]          i_req,
    input  logic [NUM_WRITERS*DATA_W-1:0]   i_data,
    input  logic [NUM_WRITERS-1:0]          i_last,
    input  logic                            i_fifo_full,
    output logic [NUM_WRITERS-1:0]          o_grant,
    output logic [NUM_WRITERS-1:0]          o_accept,
    output logic                            o_we,
    output logic [DATA_W-1:0]               o_data,
    output logic [$clog2(NUM_WRITERS)-1:0]  o_gid
`ifdef FIFO_WRITE_SCHEDULER_STATS_EN
    ,
    output logic [NUM_WRITERS*16-1:0]       o_stat_words,
    output logic [15:0]                     o_stat_stalls
`endif
);

    localparam int GW = $clog2(NUM_WRITERS);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                 state_reg, state_next;
    logic [NUM_WRITERS-1:0] grant_reg, grant_next;
    logic [GW-1:0]          gid_reg, gid_next;
    logic [GW-1:0]          rr_ptr_reg, rr_ptr_next;
    logic [CW-1:0]          burst_cnt_reg, burst_cnt_next;

    logic          accept;
    logic          release_grant;
    logic          sel_valid;
    logic [GW-1:0] sel_idx;
    int            idx;

    assign accept        = (state_reg == GRANT) && i_req[gid_reg] && !i_fifo_full;
    assign release_grant = (accept && i_last[gid_reg])
                         || (accept && (burst_cnt_reg == CW'(MAX_BURST - 1)))
                         || !i_req[gid_reg];

    assign o_grant  = grant_reg;
    assign o_gid    = gid_reg;
    assign o_we     = accept;
    assign o_accept = accept ? grant_reg : '0;
    assign o_data   = i_data[gid_reg*DATA_W +: DATA_W];

    // First requester at or above rr_ptr, wrapping; explicit subtract keeps non-power-of-two counts correct.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        for (int off = 0; off < NUM_WRITERS; off++) begin
            idx = int'(rr_ptr_reg) + off;
            if (idx >= NUM_WRITERS) begin
                idx = idx - NUM_WRITERS;
            end
            if (!sel_valid && i_req[idx]) begin
                sel_valid = 1'b1;
                sel_idx   = GW'(idx);
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        gid_next       = gid_reg;
        rr_ptr_next    = rr_ptr_reg;
        burst_cnt_next = burst_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (sel_valid) begin
                    grant_next     = NUM_WRITERS'(1) << sel_idx;
                    gid_next       = sel_idx;
                    burst_cnt_next = '0;
                    state_next     = GRANT;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    grant_next     = '0;
                    state_next     = IDLE;
                    burst_cnt_next = '0;
                    rr_ptr_next    = (gid_reg == GW'(NUM_WRITERS - 1)) ? '0 : gid_reg + 1'b1;
                end else if (accept) begin
                    burst_cnt_next = burst_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            gid_reg       <= '0;
            rr_ptr_reg    <= '0;
            burst_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            gid_reg       <= gid_next;
            rr_ptr_reg    <= rr_ptr_next;
            burst_cnt_reg <= burst_cnt_next;
        end
    end

`ifdef FIFO_WRITE_SCHEDULER_STATS_EN
    logic [15:0] stall_cnt_reg;

    generate
        for (genvar gi = 0; gi < NUM_WRITERS; gi++) begin : g_word_cnt
            logic [15:0] word_cnt_reg;
            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    word_cnt_reg <= '0;
                end else if (o_accept[gi] && (word_cnt_reg != 16'hFFFF)) begin
                    word_cnt_reg <= word_cnt_reg + 16'd1;
                end
            end
            assign o_stat_words[gi*16 +: 16] = word_cnt_reg;
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            stall_cnt_reg <= '0;
        end else if ((state_reg == GRANT) && i_req[gid_reg] && i_fifo_full
                     && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign o_stat_stalls = stall_cnt_reg;
`endif

endmodule

// File: doc/fifo_write_scheduler.md
Name: fifo_write_scheduler

Overview:
- Round-robin scheduler that shares one FIFO write port between NUM_WRITERS writer modules.
- Grants the port to one writer at a time, muxes that writer's data onto the FIFO bus and honours the FIFO full flag.
- Bounds each grant to MAX_BURST words so that no writer can starve the others.
- Sits between the writer modules and the FIFO write side.

Parameters:
- NUM_WRITERS, 4: number of requesters; must be ≥2.
- DATA_W, 8: width of each writer's data word.
- MAX_BURST, 4: maximum words accepted per grant; must be ≥1.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_req  in  NUM_WRITERS  per-writer request; high means the writer's data word is valid.
- i_data  in  NUM_WRITERS*DATA_W  flattened data buses; writer k occupies bits [k*DATA_W +: DATA_W].
- i_last  in  NUM_WRITERS  per-writer flag marking the current word as the last of its packet.
- i_fifo_full  in  1  FIFO cannot accept a write this cycle.
- o_grant  out  NUM_WRITERS  registered one-hot grant; all zero when idle.
- o_accept  out  NUM_WRITERS  combinational one-hot; word of writer k is consumed this cycle.
- o_we  out  1  FIFO write enable (combinational).
- o_data  out  DATA_W  FIFO write data (combinational mux of the granted writer's data).
- o_gid  out  $clog2(NUM_WRITERS)  index of the granted writer; valid while |o_grant.

Behaviour:
- Reset (asynchronous, i_reset_n low):
  - state=IDLE, o_grant=0, o_gid=0, rr_ptr=0, burst_cnt=0.
  - o_we=0 and o_accept=0 follow from o_grant=0.
  - o_data is don't-care but is driven as the writer-0 data word.
- Transfer rule, single-cycle with no holding register:
  - accept = state==GRANT & i_req[o_gid] & ~i_fifo_full.
  - o_we = accept.
  - o_accept = accept ? o_grant : 0.
  - o_data = i_data slice o_gid.
- Writer obligations: hold data stable while req is high and no accept has occurred; present the next word, or drop req, in the cycle after an accept.
- State IDLE:
  - If any i_req bit is set, select the first set bit searching upward from rr_ptr, wrapping modulo NUM_WRITERS.
  - On the next edge: o_grant=onehot(sel), o_gid=sel, burst_cnt=0, state=GRANT.
  - If no request, stay in IDLE.
  - Latency: req seen in IDLE at edge t → grant and first possible o_we in cycle t+1.
- State GRANT:
  - On accept, burst_cnt increments.
  - Release condition: (accept & i_last[o_gid]) | (accept & burst_cnt==MAX_BURST-1) | ~i_req[o_gid].
  - On release, at the next edge: o_grant=0, state=IDLE, rr_ptr=(o_gid+1) mod NUM_WRITERS.
  - Every release is followed by exactly one idle turnaround cycle.
  - i_fifo_full high: no accept, burst_cnt holds, grant holds indefinitely. A full FIFO does not force a release.
- Simultaneous events:
  - A request arriving while another writer is granted waits; it is never pre-empted into the current grant.
  - When all writers request continuously, grants rotate 0,1,2,3,0,… with one idle cycle between grants.
- Width rules:
  - burst_cnt is $clog2(MAX_BURST+1) bits and never exceeds MAX_BURST-1.
  - rr_ptr wrap must be correct for non-power-of-two NUM_WRITERS.
- Reset mid-burst: the grant drops asynchronously, o_we falls immediately, and the partially sent packet is not resumed.
- Invariants:
  - $onehot0(o_grant) at all times.
  - o_we implies ~i_fifo_full.
  - o_we implies state==GRANT.

Optional Feature:
- Macro: FIFO_WRITE_SCHEDULER_STATS_EN.
- When defined, adds the following ports:
  - o_stat_words  out  NUM_WRITERS*16: per-writer saturating count of accepted words.
  - o_stat_stalls  out  16: saturating count of cycles in GRANT with i_req[o_gid]&i_fifo_full.
- All counters reset to 0 and saturate at 16'hFFFF.
- When not defined, these ports and counters do not exist. Scheduling behaviour is identical in both builds.

Test Plan:
- Reset then single request:
  - Stimulus: i_req=4'b0100, i_last high on the 3rd word.
  - Response: o_grant=4'b0100 one cycle later, o_gid=2, o_we for 3 cycles, then IDLE, rr_ptr=3.
- All requesting, never last, MAX_BURST=4:
  - Stimulus: i_req=4'b1111 held continuously.
  - Response: 4 writes per grant; grant order 0,1,2,3,0; exactly one idle cycle between grants.
- FIFO full mid-burst:
  - Stimulus: i_fifo_full high for 5 cycles after the 2nd word.
  - Response: o_we=0 for those 5 cycles, grant held, burst resumes at word 3, release after word 4.
- Writer abandons request:
  - Stimulus: writer 1 granted, drops i_req after 1 word.
  - Response: release at the next edge, rr_ptr=2; a pending writer 0 is then served only after writers 2 and 3 are checked.
- Asynchronous reset mid-burst:
  - Stimulus: i_reset_n low between clock edges during a grant.
  - Response: o_grant=0 and o_we=0 immediately; after reset, the first grant goes to the lowest requester from index 0.
- STATS_EN build, replaying scenario 3:
  - Response: o_stat_words[writer]=4, o_stat_stalls=5.
